// File: rtl/cache_req_arbiter_pkg.sv
// Shared types for the cache request arbiter: memory request enums, FSM states and the
// grant index width helper.
package cache_req_arbiter_pkg;

    typedef enum logic {
        OpLoad,
        OpStore
    } memory_operation_e;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } memory_operation_size_e;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

    localparam int unsigned MaxCh = 8;

    // Index width for an n-way grant; never collapses to zero bits.
    function automatic int unsigned grant_idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Bundle of the per-channel upstream request buses and the single downstream cache port.
interface cache_req_arbiter_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_CH = 2
) ();
    import cache_req_arbiter_pkg::*;

    localparam int unsigned IdxW = grant_idx_width(NUM_CH);

    logic [NUM_CH-1:0][XLEN-1:0] up_req_address;
    memory_operation_e           up_req_operation [NUM_CH];
    memory_operation_size_e      up_req_size      [NUM_CH];
    logic [NUM_CH-1:0][XLEN-1:0] up_req_store_word;
    logic [NUM_CH-1:0]           up_req_valid;
    logic [NUM_CH-1:0][XLEN-1:0] up_req_loaded_word;
    logic [NUM_CH-1:0]           up_req_fulfilled;

    logic [XLEN-1:0]             dn_req_address;
    memory_operation_e           dn_req_operation;
    memory_operation_size_e      dn_req_size;
    logic [XLEN-1:0]             dn_req_store_word;
    logic                        dn_req_valid;
    logic [XLEN-1:0]             dn_req_loaded_word;
    logic                        dn_req_fulfilled;

    logic [IdxW-1:0]             grant_id;
    logic                        busy;

    // Arbiter side.
    modport slave (
        input  up_req_address, up_req_operation, up_req_size, up_req_store_word, up_req_valid,
        output up_req_loaded_word, up_req_fulfilled,
        output dn_req_address, dn_req_operation, dn_req_size, dn_req_store_word, dn_req_valid,
        input  dn_req_loaded_word, dn_req_fulfilled,
        output grant_id, busy
    );

    // Requesters and cache side.
    modport master (
        output up_req_address, up_req_operation, up_req_size, up_req_store_word, up_req_valid,
        input  up_req_loaded_word, up_req_fulfilled,
        input  dn_req_address, dn_req_operation, dn_req_size, dn_req_store_word, dn_req_valid,
        output dn_req_loaded_word, dn_req_fulfilled,
        input  grant_id, busy
    );

endinterface

// File: rtl/cache_req_arbiter_round_robin_picker.sv
// Combinational picker: first requesting channel at or after the start pointer (wrapping),
// or the lowest requesting channel when fixed priority is selected.
module cache_req_arbiter_round_robin_picker
    import cache_req_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_CH = 2,
    localparam int unsigned IdxW   = grant_idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IdxW-1:0]   i_start,
    input  logic              i_fixed,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IdxW-1:0]   o_idx
);

    int unsigned w_base;
    int unsigned w_dist;
    int unsigned w_best;

    // Winner is the requester with the smallest wrapped distance from the start point.
    always_comb begin
        w_base  = i_fixed ? 0 : int'(unsigned'(i_start));
        w_dist  = 0;
        w_best  = NUM_CH;
        o_grant = '0;
        o_idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dist = (unsigned'(c) + NUM_CH - w_base) % NUM_CH;
            if (i_req[c] && (w_dist < w_best)) begin
                w_best     = w_dist;
                o_grant    = '0;
                o_grant[c] = 1'b1;
                o_idx      = IdxW'(c);
            end
        end
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// N-to-1 arbiter for the cache request protocol: grants one channel, registers its request
// onto the cache port and routes the completion pulse back to that channel only.
module cache_req_arbiter
    import cache_req_arbiter_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_req_arbiter_if.slave  arb_bus
);

    localparam int unsigned IdxW = grant_idx_width(NUM_CH);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [IdxW-1:0]        r_rr_ptr;
    logic [IdxW-1:0]        r_grant_id;
    logic [NUM_CH-1:0]      r_grant_oh;
    logic [XLEN-1:0]        r_dn_address;
    logic [XLEN-1:0]        r_dn_store_word;
    memory_operation_e      r_dn_operation;
    memory_operation_size_e r_dn_size;

    logic [NUM_CH-1:0]      w_pick_oh;
    logic [IdxW-1:0]        w_pick_idx;
    logic                   w_take;

    cache_req_arbiter_round_robin_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .i_req   (arb_bus.up_req_valid),
        .i_start (r_rr_ptr),
        .i_fixed (FIXED_PRIORITY != 0),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|arb_bus.up_req_valid) begin
                    w_state_nxt = StBusy;
                    w_take      = 1'b1;
                end
            end
            StBusy: begin
                if (arb_bus.dn_req_fulfilled) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= StIdle;
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_grant_oh      <= '0;
            r_dn_address    <= '0;
            r_dn_store_word <= '0;
            r_dn_operation  <= OpLoad;
            r_dn_size       <= SizeByte;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_grant_id      <= w_pick_idx;
                r_grant_oh      <= w_pick_oh;
                r_dn_address    <= arb_bus.up_req_address[w_pick_idx];
                r_dn_store_word <= arb_bus.up_req_store_word[w_pick_idx];
                r_dn_operation  <= arb_bus.up_req_operation[w_pick_idx];
                r_dn_size       <= arb_bus.up_req_size[w_pick_idx];
                if (FIXED_PRIORITY == 0) begin
                    r_rr_ptr <= (w_pick_idx == IdxW'(NUM_CH - 1)) ? '0 : w_pick_idx + IdxW'(1);
                end
            end
        end
    end

    assign arb_bus.dn_req_valid      = (r_state == StBusy);
    assign arb_bus.busy              = (r_state == StBusy);
    assign arb_bus.grant_id          = r_grant_id;
    assign arb_bus.dn_req_address    = r_dn_address;
    assign arb_bus.dn_req_store_word = r_dn_store_word;
    assign arb_bus.dn_req_operation  = r_dn_operation;
    assign arb_bus.dn_req_size       = r_dn_size;

    // Consumers qualify the shared load word with their own fulfilled pulse.
    assign arb_bus.up_req_loaded_word = {NUM_CH{arb_bus.dn_req_loaded_word}};

    // A channel that withdrew its valid gets no pulse; the response is simply dropped.
    always_comb begin
        arb_bus.up_req_fulfilled = '0;
        if ((r_state == StBusy) && arb_bus.dn_req_fulfilled) begin
            arb_bus.up_req_fulfilled = r_grant_oh & arb_bus.up_req_valid;
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Randomised scoreboard bench: a round-robin and a fixed-priority arbiter (4 channels each)
// driven by random requesters and a random-latency cache, checked against a cycle model.
module tb_cache_req_arbiter;
    import cache_req_arbiter_pkg::*;

    localparam int unsigned NCH = 4;

    typedef struct {
        int                     ch;
        logic [31:0]            addr;
        memory_operation_e      op;
        memory_operation_size_e size;
        logic [31:0]            store;
        logic [31:0]            word;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n_done [2];
    logic [1:0] busy_v;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    // Data the cache model returns for an address.
    function automatic logic [31:0] cache_word(input logic [31:0] a);
        logic [31:0] r;
        r = {a[15:0], ~a[31:16]};
        return r ^ 32'h5A5A_0F0F;
    endfunction

    // First valid channel at or after ptr, wrapping; ptr is 0 for fixed priority.
    function automatic int pick(input logic [3:0] v, input int ptr, input bit fixed);
        int c;
        for (int k = 0; k < NCH; k++) begin
            c = ((fixed ? 0 : ptr) + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam bit Fixed = (g == 1);

        cache_req_arbiter_if #(.XLEN(32), .NUM_CH(NCH)) bus ();

        cache_req_arbiter #(
            .XLEN           (32),
            .NUM_CH         (NCH),
            .FIXED_PRIORITY (g)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .arb_bus (bus)
        );

        assign busy_v[g] = bus.busy;

        item_t sb [$];

        function automatic int find(input int ch);
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].ch == ch) return i;
            end
            return -1;
        endfunction

        // Requesters: hold fields until fulfilled, occasionally withdraw once granted.
        initial begin : req_proc
            bit active [NCH];
            bit wdrawn [NCH];
            bit got    [NCH];
            bit gr     [NCH];
            item_t it;
            for (int c = 0; c < NCH; c++) begin
                active[c] = 0;
                wdrawn[c] = 0;
                bus.up_req_address[c]    = '0;
                bus.up_req_store_word[c] = '0;
                bus.up_req_operation[c]  = OpLoad;
                bus.up_req_size[c]       = SizeByte;
            end
            bus.up_req_valid = '0;
            forever begin
                @(negedge clk);
                for (int c = 0; c < NCH; c++) begin
                    got[c] = bus.up_req_fulfilled[c];
                    gr[c]  = bus.busy && (int'(bus.grant_id) == c);
                end
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    bus.up_req_valid = '0;
                    for (int c = 0; c < NCH; c++) begin
                        active[c] = 0;
                        wdrawn[c] = 0;
                    end
                end else begin
                    for (int c = 0; c < NCH; c++) begin
                        if (wdrawn[c]) begin
                            if (!gr[c]) wdrawn[c] = 0;
                        end else if (active[c]) begin
                            if (got[c]) begin
                                bus.up_req_valid[c] = 1'b0;
                                active[c] = 0;
                            end else if (gr[c] && ($urandom_range(15) == 0)) begin
                                bus.up_req_valid[c] = 1'b0;
                                active[c] = 0;
                                wdrawn[c] = 1;
                            end
                        end else if ($urandom_range(1) == 0) begin
                            it.ch    = c;
                            it.addr  = $urandom() & 32'hFFFF_FFFC;
                            it.op    = memory_operation_e'($urandom_range(1));
                            it.size  = memory_operation_size_e'($urandom_range(2));
                            it.store = $urandom();
                            it.word  = cache_word(it.addr);
                            bus.up_req_address[c]    = it.addr;
                            bus.up_req_operation[c]  = it.op;
                            bus.up_req_size[c]       = it.size;
                            bus.up_req_store_word[c] = it.store;
                            bus.up_req_valid[c]      = 1'b1;
                            sb.push_back(it);
                            active[c] = 1;
                        end
                    end
                end
            end
        end

        // Cache: answers after 0..3 busy cycles; sometimes pulses fulfilled while idle.
        initial begin : cache_proc
            int  cnt;
            int  lat;
            bit  served;
            cnt = 0;
            lat = 0;
            served = 0;
            bus.dn_req_fulfilled   = 1'b0;
            bus.dn_req_loaded_word = '0;
            forever begin
                @(posedge clk);
                #1;
                bus.dn_req_fulfilled   = 1'b0;
                bus.dn_req_loaded_word = $urandom();
                if (bus.dn_req_valid) begin
                    if (!served) begin
                        if (cnt >= lat) begin
                            bus.dn_req_fulfilled   = 1'b1;
                            bus.dn_req_loaded_word = cache_word(bus.dn_req_address);
                            served = 1;
                        end else begin
                            cnt++;
                        end
                    end
                end else begin
                    served = 0;
                    cnt    = 0;
                    lat    = $urandom_range(3);
                    if ($urandom_range(7) == 0) bus.dn_req_fulfilled = 1'b1;
                end
            end
        end

        // Monitor and reference model, evaluated once per cycle on the falling edge.
        initial begin : mon_proc
            bit         e_busy;
            int         e_gnt;
            int         e_ptr;
            int         idx;
            item_t      e_it;
            logic [3:0] v;
            logic [3:0] e_ful;
            e_busy = 0;
            e_gnt  = 0;
            e_ptr  = 0;
            n_done[g] = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    e_busy = 0;
                    e_gnt  = 0;
                    e_ptr  = 0;
                    sb.delete();
                end else begin
                    v = bus.up_req_valid;
                    chk("dn_valid", g, 32'(bus.dn_req_valid), 32'(e_busy));
                    chk("busy", g, 32'(bus.busy), 32'(e_busy));
                    if (e_busy) begin
                        chk("grant_id", g, 32'(bus.grant_id), 32'(e_gnt));
                        chk("dn_address", g, bus.dn_req_address, e_it.addr);
                        chk("dn_operation", g, 32'(bus.dn_req_operation), 32'(e_it.op));
                        chk("dn_size", g, 32'(bus.dn_req_size), 32'(e_it.size));
                        chk("dn_store_word", g, bus.dn_req_store_word, e_it.store);
                    end
                    e_ful = '0;
                    if (e_busy && bus.dn_req_fulfilled && v[2'(e_gnt)]) e_ful[2'(e_gnt)] = 1'b1;
                    chk("up_fulfilled", g, 32'(bus.up_req_fulfilled), 32'(e_ful));
                    chk("loaded_bcast", g, bus.up_req_loaded_word[$urandom_range(NCH - 1)],
                        bus.dn_req_loaded_word);
                    if (e_busy && bus.dn_req_fulfilled) begin
                        idx = find(e_gnt);
                        if (idx >= 0) begin
                            if (v[2'(e_gnt)]) begin
                                chk("loaded_word", g, bus.up_req_loaded_word[e_gnt],
                                    sb[idx].word);
                                n_done[g]++;
                            end
                            sb.delete(idx);
                        end
                        e_busy = 0;
                    end else if (!e_busy && (|v)) begin
                        e_gnt = pick(v, e_ptr, Fixed);
                        idx   = find(e_gnt);
                        chk("sb_has_item", g, 32'(idx >= 0), 32'd1);
                        if (idx >= 0) e_it = sb[idx];
                        e_busy = 1;
                        if (!Fixed) e_ptr = (e_gnt + 1) % NCH;
                    end
                end
            end
        end

        // Outputs must reach reset values as soon as rst_n falls, with no clock edge.
        initial begin : rst_chk
            forever begin
                @(negedge rst_n);
                #1;
                chk("rst_dn_valid", g, 32'(bus.dn_req_valid), 32'd0);
                chk("rst_busy", g, 32'(bus.busy), 32'd0);
                chk("rst_grant_id", g, 32'(bus.grant_id), 32'd0);
                chk("rst_dn_address", g, bus.dn_req_address, 32'd0);
                chk("rst_dn_store", g, bus.dn_req_store_word, 32'd0);
                chk("rst_dn_op", g, 32'(bus.dn_req_operation), 32'(OpLoad));
                chk("rst_dn_size", g, 32'(bus.dn_req_size), 32'(SizeByte));
                chk("rst_fulfilled", g, 32'(bus.up_req_fulfilled), 32'd0);
            end
        end
    end

    initial begin : main
        bit hit;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3000) @(posedge clk);

        // Abort a transaction in flight on the round-robin instance.
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (busy_v[0]) hit = 1;
        end
        chk("busy_before_abort", 0, 32'(hit), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2000) @(posedge clk);

        for (int g = 0; g < 2; g++) begin
            chk("activity", g, 32'(n_done[g] > 100), 32'd1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Parametrised N-to-1 arbiter for the cache request protocol. It sits between NUM_CH requesters (instruction fetch, data port, debug, ...) and a single cache port. It grants one requester at a time, either round-robin or by fixed priority, and forwards that requester's request on registered outputs. It routes the cache response back to the granted channel only and holds the grant until the transaction completes.

## Interface
Parameters:
- XLEN, 32, address/data width
- NUM_CH, 2, number of requesting channels (2..8)
- FIXED_PRIORITY, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- up_req_address  in  NUM_CH x XLEN  per-channel request address
- up_req_operation  in  NUM_CH x memory_operation_e  per-channel load/store
- up_req_size  in  NUM_CH x memory_operation_size_e  per-channel access size
- up_req_store_word  in  NUM_CH x XLEN  per-channel store data
- up_req_valid  in  NUM_CH  per-channel request valid
- up_req_loaded_word  out  NUM_CH x XLEN  per-channel load data
- up_req_fulfilled  out  NUM_CH  per-channel completion pulse
- dn_req_address  out  XLEN  to cache
- dn_req_operation  out  memory_operation_e  to cache
- dn_req_size  out  memory_operation_size_e  to cache
- dn_req_store_word  out  XLEN  to cache
- dn_req_valid  out  1  to cache
- dn_req_loaded_word  in  XLEN  from cache
- dn_req_fulfilled  in  1  from cache
- grant_id  out  $clog2(NUM_CH)  index of the channel currently granted; valid while busy
- busy  out  1  a downstream transaction is outstanding

## Operation
- Protocol on both sides:
  - Requester raises req_valid and holds all fields stable until req_fulfilled.
  - req_fulfilled is a single-cycle pulse; req_loaded_word is valid in that cycle.
- State machine, arb_state_e: IDLE, BUSY.
- IDLE:
  - If any up_req_valid is set, select one channel (see below).
  - Register that channel's address, operation, size and store word into the dn_* registers.
  - Set dn_req_valid=1, busy=1, grant_id=selected channel; go to BUSY.
  - If no up_req_valid is set, stay in IDLE.
- BUSY:
  - dn_* outputs are held constant.
  - When dn_req_fulfilled=1:
    - up_req_fulfilled[grant_id]=1 combinationally in the same cycle.
    - up_req_loaded_word[grant_id]=dn_req_loaded_word.
    - Next cycle: dn_req_valid=0, busy=0; go to IDLE.
- Selection:
  - Round-robin: a pointer rr_ptr is reset to 0. The search starts at rr_ptr and wraps modulo NUM_CH. On every grant, rr_ptr is set to (granted+1) mod NUM_CH.
  - Fixed priority: the lowest-index valid channel wins; rr_ptr is unused.
- Non-granted channels always see up_req_fulfilled=0.
- up_req_loaded_word of every channel is driven with dn_req_loaded_word at all times; consumers qualify it with their own fulfilled pulse.
- Withdrawn request: if the granted channel drops up_req_valid before completion (a protocol violation), the downstream transaction still completes. up_req_fulfilled is suppressed for that channel, and the response is discarded.
- dn_req_fulfilled while in IDLE is ignored.

## Timing
- Reset values:
  - dn_req_valid=0, busy=0, grant_id=0, rr_ptr=0.
  - dn_req_address, dn_req_store_word = 0.
  - dn_req_operation, dn_req_size = first enumerator of their type.
  - up_req_fulfilled all 0; state=IDLE.
- Request latency: up_req_valid seen at edge N gives dn_req_valid=1 after edge N.
- Response latency: zero cycles; up_req_fulfilled is combinational from dn_req_fulfilled.
- Turnaround: one IDLE bubble cycle after each fulfilled pulse. Back-to-back grants are spaced by at least (cache latency + 1) cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. All other requesters wait, with their fields held.
- A requester whose valid is still high in the fulfilled cycle is not regranted. Its valid is expected to drop, and the IDLE bubble guarantees this.
- Reset mid-transaction: rst_n low forces all outputs to their reset values immediately, without waiting for a clock edge. No fulfilled pulse is issued for the aborted request.

## Structure
- torrence_types gains:
  - arb_state_e {IDLE, BUSY}.
  - A localparam helper for the grant index width.
  - memory_operation_e and memory_operation_size_e are reused unchanged.
- Sub-module round_robin_picker:
  - Combinational; parameter NUM_CH.
  - Inputs: request vector, start pointer, fixed-priority flag.
  - Outputs: one-hot grant and encoded index.
- cache_req_arbiter contains the FSM, the dn_* registers, rr_ptr and the response demultiplexer.

## Test plan
- Single channel: ch1 loads 0x0000_1000; cache fulfils 3 cycles later with 0xDEAD_BEEF. Required: dn_req_valid one cycle after request; ch1 gets the fulfilled pulse with 0xDEAD_BEEF; ch0 fulfilled stays 0.
- Round-robin fairness: NUM_CH=4, all valid continuously, each fulfilled after 1 cycle. Required grant order 0,1,2,3,0,1; grant_id matches each dn transaction.
- Fixed priority: FIXED_PRIORITY=1, ch0 and ch2 valid continuously. Required: ch0 granted on every arbitration; ch2 starves until ch0 drops.
- Store forwarding: ch0 issues a store of 0x1234_5678, size word. Required: dn fields equal the ch0 fields and are stable until fulfilled; busy=1 throughout.
- Withdrawn request: ch1 granted, drops valid before fulfilled. Required: transaction completes, no up_req_fulfilled pulse, next state is IDLE.
- Async reset in BUSY: rst_n low mid-transaction. Required: dn_req_valid=0, busy=0, rr_ptr=0 before the next clock edge. After release, the first grant goes to the lowest valid channel.
